// File: rtl/tx_sched_pkg.sv
// Shared encodings for the upstream tx packet scheduler: FSM states and
// grant source codes, also used by the bench monitor.
package tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        LOAD        = 3'd2,
        WAIT_ACCEPT = 3'd3,
        WAIT_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        REPLY = 2'd1,
        FWD   = 2'd2,
        FIFO  = 2'd3
    } grant_src_t;

endpackage

// File: rtl/tx_packet_scheduler.sv
// Arbitrates the upstream UART transmitter between regmap replies, forwarded
// packets and the local event FIFO, with anti-starvation for FIFO events.
module tx_packet_scheduler
    import tx_sched_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int STARVE_LIMIT   = 4,
    parameter int ACCEPT_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             reply_valid,
    input  logic [WIDTH-2:0] reply_data,
    output logic             reply_ack,
    input  logic             fwd_valid,
    input  logic [WIDTH-2:0] fwd_data,
    output logic             fwd_ack,
    input  logic             fifo_empty,
    input  logic [WIDTH-2:0] fifo_data,
    output logic             read_fifo_n,
    input  logic             tx_busy,
    output logic             ld_tx_data,
    output logic [WIDTH-2:0] tx_data_out,
    output logic [1:0]       grant_src
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TMO_LAST   = TO_W'(ACCEPT_TIMEOUT - 1);

    state_t          state;
    logic [SC_W-1:0] starve_cnt;
    logic [TO_W-1:0] tmo_cnt;

    logic can_grant;
    logic fifo_force;
    logic pick_reply;
    logic pick_fwd;
    logic pick_fifo;

    // FIFO override beats the fixed REPLY > FWD > FIFO order once the
    // starve counter has saturated.
    always_comb begin
        can_grant  = (state == IDLE) && tx_enable && !tx_busy;
        fifo_force = (starve_cnt == STARVE_MAX) && !fifo_empty;
        pick_reply = 1'b0;
        pick_fwd   = 1'b0;
        pick_fifo  = 1'b0;
        if (can_grant) begin
            if (fifo_force)       pick_fifo  = 1'b1;
            else if (reply_valid) pick_reply = 1'b1;
            else if (fwd_valid)   pick_fwd   = 1'b1;
            else if (!fifo_empty) pick_fifo  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            tmo_cnt     <= '0;
            reply_ack   <= 1'b0;
            fwd_ack     <= 1'b0;
            read_fifo_n <= 1'b1;
            ld_tx_data  <= 1'b0;
            tx_data_out <= '0;
            grant_src   <= NONE;
        end else begin
            reply_ack   <= 1'b0;
            fwd_ack     <= 1'b0;
            read_fifo_n <= 1'b1;
            ld_tx_data  <= 1'b0;

            if (fifo_empty || pick_fifo)
                starve_cnt <= '0;
            else if ((pick_reply || pick_fwd) && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (pick_reply) begin
                        tx_data_out <= reply_data;
                        reply_ack   <= 1'b1;
                        grant_src   <= REPLY;
                        state       <= LOAD;
                    end else if (pick_fwd) begin
                        tx_data_out <= fwd_data;
                        fwd_ack     <= 1'b1;
                        grant_src   <= FWD;
                        state       <= LOAD;
                    end else if (pick_fifo) begin
                        read_fifo_n <= 1'b0;
                        grant_src   <= FIFO;
                        state       <= FETCH;
                    end
                end
                // Pop lands on this edge; the head word is still on fifo_data.
                FETCH: begin
                    tx_data_out <= fifo_data;
                    state       <= LOAD;
                end
                LOAD: begin
                    ld_tx_data <= 1'b1;
                    tmo_cnt    <= '0;
                    state      <= WAIT_ACCEPT;
                end
                // The strobe cycle itself counts toward the accept timeout;
                // a retry re-strobes the held data without re-pop or re-ack.
                WAIT_ACCEPT: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                    else if (tmo_cnt == TMO_LAST)
                        state <= LOAD;
                    else
                        tmo_cnt <= tmo_cnt + 1'b1;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler with a small UART, FIFO and
// requester model driven from one linear stimulus sequence.
module tb_tx_packet_scheduler;
    import tx_sched_pkg::*;

    localparam int WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             tx_enable;
    logic             reply_valid;
    logic [WIDTH-2:0] reply_data;
    logic             reply_ack;
    logic             fwd_valid;
    logic [WIDTH-2:0] fwd_data;
    logic             fwd_ack;
    logic             fifo_empty;
    logic [WIDTH-2:0] fifo_data;
    logic             read_fifo_n;
    logic             tx_busy;
    logic             ld_tx_data;
    logic [WIDTH-2:0] tx_data_out;
    logic [1:0]       grant_src;

    tx_packet_scheduler #(
        .WIDTH(WIDTH), .STARVE_LIMIT(4), .ACCEPT_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable),
        .reply_valid(reply_valid), .reply_data(reply_data), .reply_ack(reply_ack),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_ack(fwd_ack),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .read_fifo_n(read_fifo_n),
        .tx_busy(tx_busy), .ld_tx_data(ld_tx_data), .tx_data_out(tx_data_out),
        .grant_src(grant_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-2:0] fifo_q[$];
    logic [WIDTH-2:0] rq[$];
    logic [WIDTH-2:0] fq[$];
    int busy_cnt, dly_cnt, uart_len, uart_delay, cyc;
    logic p_rd_n, p_ld, p_rack, p_fack;

    int n_ld, n_rack, n_fack, n_pop, rack_cyc;
    logic [WIDTH-2:0] ld_data[$];
    logic [1:0]       ld_src[$];
    int               ld_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic clear_mon();
        n_ld = 0; n_rack = 0; n_fack = 0; n_pop = 0; rack_cyc = -1;
        ld_data.delete(); ld_src.delete(); ld_cyc.delete();
    endtask

    // One clock: models react to what the DUT drove during the cycle that
    // just ended, then the new outputs are logged.
    task automatic step();
        logic [WIDTH-2:0] tmp;
        @(posedge clk);
        #1;
        cyc++;
        if (!p_rd_n && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        if (dly_cnt > 0) begin
            dly_cnt--;
            if (dly_cnt == 0) busy_cnt = uart_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (p_ld && busy_cnt == 0 && dly_cnt == 0) begin
            if (uart_delay == 0) busy_cnt = uart_len;
            else dly_cnt = uart_delay;
        end
        tx_busy = (busy_cnt > 0);
        if (p_rack) reply_valid = 1'b0;
        else if (!reply_valid && rq.size() > 0) begin
            reply_data = rq.pop_front(); reply_valid = 1'b1;
        end
        if (p_fack) fwd_valid = 1'b0;
        else if (!fwd_valid && fq.size() > 0) begin
            fwd_data = fq.pop_front(); fwd_valid = 1'b1;
        end
        if (ld_tx_data) begin
            n_ld++; ld_data.push_back(tx_data_out); ld_src.push_back(grant_src); ld_cyc.push_back(cyc);
        end
        if (!read_fifo_n) n_pop++;
        if (reply_ack) begin n_rack++; rack_cyc = cyc; end
        if (fwd_ack) n_fack++;
        p_rd_n = read_fifo_n; p_ld = ld_tx_data; p_rack = reply_ack; p_fack = fwd_ack;
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int exp_src[17] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};

    initial begin
        int ri, fi;
        logic [WIDTH-2:0] exp_d;
        reset = 1'b1; tx_enable = 1'b1; reply_valid = 1'b0; reply_data = '0;
        fwd_valid = 1'b0; fwd_data = '0; tx_busy = 1'b0;
        busy_cnt = 0; dly_cnt = 0; uart_len = 64; uart_delay = 0; cyc = 0;
        p_rd_n = 1'b1; p_ld = 1'b0; p_rack = 1'b0; p_fack = 1'b0;
        drive_fifo();
        clear_mon();

        // Reset values
        run(3);
        check("rst_reply_ack", reply_ack, 0);
        check("rst_fwd_ack", fwd_ack, 0);
        check("rst_read_fifo_n", read_fifo_n, 1);
        check("rst_ld_tx_data", ld_tx_data, 0);
        check("rst_tx_data_out", tx_data_out, 0);
        check("rst_grant_src", grant_src, 0);
        check("rst_state", dut.state, IDLE);
        reset = 1'b0;
        run(2);

        // Single FIFO event with a 64-cycle UART
        clear_mon();
        fifo_q.push_back(63'h1234); drive_fifo();
        step();
        check("fifo_pop_k1", read_fifo_n, 0);
        check("fifo_src_k1", grant_src, 3);
        check("fifo_ld_k1", ld_tx_data, 0);
        step();
        check("fifo_pop_k2", read_fifo_n, 1);
        check("fifo_data_k2", tx_data_out, 63'h1234);
        check("fifo_ld_k2", ld_tx_data, 0);
        step();
        check("fifo_ld_k3", ld_tx_data, 1);
        check("fifo_data_k3", tx_data_out, 63'h1234);
        check("fifo_src_k3", grant_src, 3);
        step();
        check("fifo_ld_k4", ld_tx_data, 0);
        run(80);
        check("fifo_pops", n_pop, 1);
        check("fifo_strobes", n_ld, 1);
        check("fifo_idle_after", dut.state, IDLE);

        // Reply and forward requested on the same edge
        uart_len = 4;
        clear_mon();
        rq.push_back(63'h0AAA); fq.push_back(63'h0BBB);
        run(40);
        check("both_strobes", n_ld, 2);
        check("both_first_src", ld_src[0], 1);
        check("both_first_data", ld_data[0], 63'h0AAA);
        check("both_second_src", ld_src[1], 2);
        check("both_second_data", ld_data[1], 63'h0BBB);
        check("both_reply_acks", n_rack, 1);
        check("both_fwd_acks", n_fack, 1);
        check("reply_ack_to_ld", ld_cyc[0] - rack_cyc, 1);

        // Continuous replies against three FIFO events
        uart_len = 2;
        clear_mon();
        for (int i = 0; i < 14; i++) rq.push_back(63'h100 + 63'(i));
        reply_data = rq.pop_front(); reply_valid = 1'b1;
        for (int i = 0; i < 3; i++) fifo_q.push_back(63'hA0 + 63'(i));
        drive_fifo();
        run(200);
        check("starve_strobes", n_ld, 17);
        check("starve_pops", n_pop, 3);
        ri = 0; fi = 0;
        for (int i = 0; i < 17; i++) begin
            if (exp_src[i] == 3) begin exp_d = 63'hA0 + 63'(fi); fi++; end
            else begin exp_d = 63'h100 + 63'(ri); ri++; end
            check($sformatf("starve_src_%0d", i), ld_src[i], 64'(exp_src[i]));
            check($sformatf("starve_data_%0d", i), ld_data[i], exp_d);
        end

        // tx_enable low with every source pending
        tx_enable = 1'b0;
        clear_mon();
        rq.push_back(63'h0C01); fq.push_back(63'h0C02);
        fifo_q.push_back(63'h0C03); drive_fifo();
        run(30);
        check("dis_strobes", n_ld, 0);
        check("dis_reply_acks", n_rack, 0);
        check("dis_fwd_acks", n_fack, 0);
        check("dis_pops", n_pop, 0);
        tx_enable = 1'b1;
        clear_mon();
        step();
        check("en_reply_ack", reply_ack, 1);
        run(60);
        check("en_strobes", n_ld + 1 - 1, 3);
        check("en_src0", ld_src[0], 1);
        check("en_src1", ld_src[1], 2);
        check("en_src2", ld_src[2], 3);
        check("en_data2", ld_data[2], 63'h0C03);

        // UART ignores the first strobe for 20 cycles
        uart_delay = 20; uart_len = 4;
        clear_mon();
        fifo_q.push_back(63'h5A5A); drive_fifo();
        run(70);
        check("tmo_strobes", n_ld, 2);
        check("tmo_data0", ld_data[0], 63'h5A5A);
        check("tmo_data1", ld_data[1], 63'h5A5A);
        check("tmo_src1", ld_src[1], 3);
        check("tmo_gap", ld_cyc[1] - ld_cyc[0], 16);
        check("tmo_pops", n_pop, 1);
        uart_delay = 0;

        // Reset during WAIT_DONE with another reply pending
        uart_len = 10;
        clear_mon();
        reply_data = 63'h0D01; reply_valid = 1'b1;
        rq.push_back(63'h0D02);
        run(6);
        check("rd_state_wait_done", dut.state, WAIT_DONE);
        check("rd_pending_valid", reply_valid, 1);
        reset = 1'b1;
        step();
        check("rd_reply_ack", reply_ack, 0);
        check("rd_fwd_ack", fwd_ack, 0);
        check("rd_read_fifo_n", read_fifo_n, 1);
        check("rd_ld_tx_data", ld_tx_data, 0);
        check("rd_tx_data_out", tx_data_out, 0);
        check("rd_grant_src", grant_src, 0);
        check("rd_state", dut.state, IDLE);
        reset = 1'b0;
        clear_mon();
        run(40);
        check("rd_resend_strobes", n_ld, 1);
        check("rd_resend_acks", n_rack, 1);
        check("rd_resend_data", ld_data[0], 63'h0D02);
        check("rd_resend_src", ld_src[0], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
